// File: rtl/sd_sector_arbiter.sv
`default_nettype none
// ============================================================================
// sd_sector_arbiter -- round-robin arbiter granting loader/glue sector
// requests onto the single hps_io SD port. Optional ack watchdog: SD_ARB_TIMEOUT_EN
// Rev 1.0
// ============================================================================
module sd_sector_arbiter #(
   parameter int TIMEOUT_CYCLES = 10_000_000
) (
   input  logic       clk_100m,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic [1:0] req_wr,
   input  logic [8:0] req_lba0,
   input  logic [8:0] req_lba1,
   output logic [1:0] done,
   output logic [1:0] err,
   output logic       busy,
   output logic       owner,
   output logic [8:0] sd_lba,
   output logic       sd_rd,
   output logic       sd_wr,
   input  logic       sd_ack
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ISSUE    = 3'd1,
      S_WAIT_ACK = 3'd2,
      S_XFER     = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic       r_owner;
   logic       r_dir_wr;
   logic       r_last;
   logic       r_rd;
   logic       r_wr;
   logic [8:0] r_lba;
   logic [1:0] r_done;
   logic       w_gnt;
   logic       w_timeout;
   logic       w_strobe_nxt;
   logic [1:0] w_owner_oh;

   if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 16777216)) begin : g_bad_timeout
      $error("sd_sector_arbiter: TIMEOUT_CYCLES must lie in 2..2^24");
   end

   // Under contention the requester not served last wins.
   assign w_gnt      = (req == 2'b11) ? ~r_last : req[1];
   assign w_owner_oh = r_owner ? 2'b10 : 2'b01;

   always_ff @(posedge clk_100m) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (|req) w_state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            w_state_nxt = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (w_timeout)   w_state_nxt = S_DONE;
            else if (sd_ack) w_state_nxt = S_XFER;
         end
         S_XFER: begin
            if (w_timeout || !sd_ack) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Strobes are registered, so they follow the state one edge later.
   assign w_strobe_nxt = (w_state_nxt == S_WAIT_ACK);

   always_ff @(posedge clk_100m) begin
      if (reset) begin
         r_owner  <= 1'b0;
         r_dir_wr <= 1'b0;
         r_lba    <= 9'd0;
         r_last   <= 1'b1;
         r_rd     <= 1'b0;
         r_wr     <= 1'b0;
         r_done   <= 2'b00;
      end else begin
         if ((r_state == S_IDLE) && (|req)) begin
            r_owner  <= w_gnt;
            r_dir_wr <= req_wr[w_gnt];
            r_lba    <= w_gnt ? req_lba1 : req_lba0;
         end
         if (r_state == S_DONE) r_last <= r_owner;
         r_rd   <= w_strobe_nxt & ~r_dir_wr;
         r_wr   <= w_strobe_nxt &  r_dir_wr;
         r_done <= (w_state_nxt == S_DONE) ? w_owner_oh : 2'b00;
      end
   end

`ifdef SD_ARB_TIMEOUT_EN
   localparam logic [23:0] c_wd_limit = 24'(TIMEOUT_CYCLES - 1);

   logic [23:0] r_wd;
   logic [1:0]  r_err;

   always_ff @(posedge clk_100m) begin
      if (reset) begin
         r_wd  <= 24'd0;
         r_err <= 2'b00;
      end else begin
         if (r_state == S_ISSUE) begin
            r_wd <= 24'd0;
         end else if ((r_state == S_WAIT_ACK) || (r_state == S_XFER)) begin
            r_wd <= r_wd + 24'd1;
         end
         r_err <= ((w_state_nxt == S_DONE) && w_timeout) ? w_owner_oh : 2'b00;
      end
   end

   assign w_timeout = ((r_state == S_WAIT_ACK) || (r_state == S_XFER)) && (r_wd == c_wd_limit);
   assign err       = r_err;
`else
   assign w_timeout = 1'b0;
   assign err       = 2'b00;
`endif

   assign busy   = (r_state != S_IDLE);
   assign owner  = r_owner;
   assign sd_lba = busy ? r_lba : 9'd0;
   assign sd_rd  = r_rd;
   assign sd_wr  = r_wr;
   assign done   = r_done;

endmodule
`default_nettype wire
